// File: rtl/capp_pkg.sv
// Shared SR action encoding for the CAPP array.
// Used by srff_behave for next-state and by cells to build strobes.
package capp_pkg;

    typedef enum logic [1:0] {
        SR_HOLD     = 2'b00,
        SR_CLR      = 2'b01,
        SR_SET      = 2'b10,
        SR_CONFLICT = 2'b11
    } sr_act_e;

    function automatic sr_act_e sr_act(logic s, logic r);
        return sr_act_e'({s, r});
    endfunction

    // Hold when s==r, else follow s; X on s or r propagates.
    function automatic logic sr_next(logic q, logic s, logic r);
        return (s & ~r) | (q & ~(s ^ r));
    endfunction

endpackage

// File: rtl/srff_behave_if.sv
// Strobe/state bundle for a bank of SR flip-flops.
// Master drives strobes, slave returns state.
interface srff_behave_if #(
    parameter int WIDTH = 1
);
    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qn;
    logic [WIDTH-1:0] conflict;

    modport master (
        output s, r,
        input  q, qn, conflict
    );

    modport slave (
        input  s, r,
        output q, qn, conflict
    );
endinterface

// File: rtl/srff_behave.sv
// Behavioural bank of WIDTH independent set/reset flip-flops.
// Leaf storage primitive of the CAPP cells array.
module srff_behave
    import capp_pkg::*;
#(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    output logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    input  logic             CLK,
    input  logic             RST_N,
    output logic [WIDTH-1:0] qn,
    output logic [WIDTH-1:0] conflict
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;
    logic [WIDTH-1:0] cf_q;
    logic [WIDTH-1:0] cf_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign q_d[i] = sr_next(q_q[i], s[i], r[i]);
    end

    assign cf_d = s & r;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            q_q  <= RESET_VALUE;
            cf_q <= '0;
        end else begin
            q_q  <= q_d;
            cf_q <= cf_d;
        end
    end

    assign q        = q_q;
    assign qn       = ~q_q;
    assign conflict = cf_q;

`ifdef ASSERT_ON
    // Illegal strobe pair is tolerated, so only flag it.
    a_no_conflict: assert property (
        @(posedge CLK) disable iff (!RST_N)
        (s & r) == '0
    ) else $warning("srff_behave: s and r asserted together");

    a_rst_val: assert property (
        @(posedge CLK) !RST_N |-> q == RESET_VALUE
    );

    a_hold: assert property (
        @(posedge CLK) disable iff (!RST_N)
        1'b1 |=> ((q ^ $past(q)) & ~$past(s | r)) == '0
    );
`endif

endmodule

// File: tb/tb_srff_behave.sv
// Directed bench: 4-bit bank via interface plus a 100x32 cells-style array.
module tb_srff_behave;
    import capp_pkg::*;

    localparam int NW = 100;
    localparam int BW = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   n_run = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    srff_behave_if #(.WIDTH(4)) sr_if ();

    srff_behave #(
        .WIDTH(4),
        .RESET_VALUE(4'b1010)
    ) u_dut (
        .q(sr_if.q),
        .s(sr_if.s),
        .r(sr_if.r),
        .CLK(clk),
        .RST_N(rst_n),
        .qn(sr_if.qn),
        .conflict(sr_if.conflict)
    );

    logic [NW-1:0]   tag;
    logic [2*BW-1:0] wl;
    logic [BW-1:0]   aq  [NW];
    logic [BW-1:0]   aqn [NW];
    logic [BW-1:0]   acf [NW];

    for (genvar w = 0; w < NW; w++) begin : g_word
        logic [BW-1:0] ws;
        logic [BW-1:0] wr;
        for (genvar j = 0; j < BW; j++) begin : g_b
            assign ws[j] = tag[w] & wl[2*j];
            assign wr[j] = tag[w] & wl[2*j+1];
        end
        srff_behave #(
            .WIDTH(BW),
            .RESET_VALUE(BW'(w))
        ) u_word (
            .q(aq[w]),
            .s(ws),
            .r(wr),
            .CLK(clk),
            .RST_N(rst_n),
            .qn(aqn[w]),
            .conflict(acf[w])
        );
    end

    task automatic check(input string tag_s, input logic [31:0] got,
                         input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag_s, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*BW-1:0] enc(logic [BW-1:0] v);
        logic [2*BW-1:0] e;
        sr_act_e a;
        e = '0;
        for (int j = 0; j < BW; j++) begin
            a = v[j] ? SR_SET : SR_CLR;
            e[2*j]   = a[1];
            e[2*j+1] = a[0];
        end
        return e;
    endfunction

    initial begin
        int bad;
        sr_if.s = '0;
        sr_if.r = '0;
        tag = '0;
        wl  = '0;

        // async reset before any clock edge
        #2 rst_n = 1'b0;
        #1;
        check("rst_q",  32'(sr_if.q),        32'h0000_000a);
        check("rst_qn", 32'(sr_if.qn),       32'h0000_0005);
        check("rst_cf", 32'(sr_if.conflict), 32'h0);
        check("rst_arr5", aq[5], 32'd5);

        @(negedge clk);
        rst_n = 1'b1;
        sr_if.s = 4'b0001;
        sr_if.r = 4'b1000;
        tick();
        check("set_clr_q",  32'(sr_if.q),        32'h3);
        check("set_clr_qn", 32'(sr_if.qn),       32'hc);
        check("set_clr_cf", 32'(sr_if.conflict), 32'h0);

        sr_if.s = '0;
        sr_if.r = '0;
        for (int k = 0; k < 3; k++) begin
            tick();
            check("hold_q", 32'(sr_if.q), 32'h3);
        end

        sr_if.s = 4'b0100;
        sr_if.r = 4'b0100;
        tick();
        check("conf0_q",  32'(sr_if.q),        32'h3);
        check("conf0_cf", 32'(sr_if.conflict), 32'h4);
        sr_if.s = '0;
        sr_if.r = '0;
        tick();
        check("conf0_clr", 32'(sr_if.conflict), 32'h0);

        sr_if.s = 4'b0001;
        sr_if.r = 4'b0001;
        tick();
        check("conf1_q",  32'(sr_if.q),        32'h3);
        check("conf1_cf", 32'(sr_if.conflict), 32'h1);
        sr_if.s = '0;
        sr_if.r = '0;
        tick();
        check("conf1_clr", 32'(sr_if.conflict), 32'h0);

        // reset asserted on the same edge as a set strobe
        sr_if.s = 4'b1111;
        @(posedge clk);
        rst_n = 1'b0;
        #1;
        check("rpri_q",  32'(sr_if.q),        32'ha);
        check("rpri_cf", 32'(sr_if.conflict), 32'h0);
        tick();
        check("rpri_held", 32'(sr_if.q), 32'ha);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("rrel_q", 32'(sr_if.q), 32'hf);

        sr_if.s = '0;
        sr_if.r = 4'b0101;
        tick();
        check("clr_q", 32'(sr_if.q), 32'ha);
        sr_if.r = '0;

        // strobes pulsed between edges
        sr_if.s = 4'b0101;
        #3 sr_if.s = '0;
        tick();
        check("glitch_s", 32'(sr_if.q), 32'ha);
        sr_if.r = 4'b1010;
        #3 sr_if.r = '0;
        tick();
        check("glitch_r", 32'(sr_if.q), 32'ha);

        // array write of one word
        tag[5] = 1'b1;
        wl = enc(32'hDEAD_BEEF);
        tick();
        check("arr_w5", aq[5], 32'hDEAD_BEEF);
        check("arr_w5n", aqn[5], 32'h2152_4110);
        bad = 0;
        for (int w = 0; w < NW; w++)
            if (w != 5 && aq[w] !== BW'(w)) bad++;
        check("arr_others", 32'(bad), 32'h0);

        tag = '0;
        wl = enc(32'h1234_5678);
        tick();
        check("arr_w5_hold", aq[5], 32'hDEAD_BEEF);

        tag[7] = 1'b1;
        wl = enc(32'h0000_0000);
        tick();
        check("arr_w7_clr", aq[7], 32'h0);
        check("arr_w5_keep", aq[5], 32'hDEAD_BEEF);
        tag = '0;
        wl  = '0;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
